// File: rtl/proj_minhash_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : proj_minhash_sweep
//  Description : Swaps feature-map banks, sweeps fragment indices and folds
//                HASH_COUNT affine hashes into a MinHash signature.
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_minhash_sweep #(
    parameter int FRAG_LEN          = 16,
    parameter int SIGNED_INDICE_LEN = 6,
    parameter int FRAG_START        = -4,
    parameter int FRAG_END          = 24,
    parameter int HASH_COUNT        = 4,
    parameter int HASH_BITS         = 16,
    parameter logic [HASH_COUNT*HASH_BITS-1:0] HASH_A =
        {16'h27D4, 16'hC2B2, 16'h85EB, 16'h9E37},
    parameter logic [HASH_COUNT*HASH_BITS-1:0] HASH_B =
        {16'h0007, 16'h0005, 16'h0003, 16'h0001}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              fm_wait,
    input  logic [FRAG_LEN-1:0]               frag_data,
    output logic [SIGNED_INDICE_LEN-1:0]      frag_idx,
    output logic                              chg_idx,
    output logic                              sig_valid,
    input  logic                              sig_ready,
    output logic [HASH_COUNT*HASH_BITS-1:0]   sig_data,
    output logic                              busy
);

    localparam int c_SIG_W = HASH_COUNT * HASH_BITS;
    localparam logic [SIGNED_INDICE_LEN-1:0] c_START_IDX = FRAG_START[SIGNED_INDICE_LEN-1:0];
    localparam logic [SIGNED_INDICE_LEN-1:0] c_END_IDX   = FRAG_END[SIGNED_INDICE_LEN-1:0];
    localparam logic [SIGNED_INDICE_LEN-1:0] c_IDX_ONE   = {{(SIGNED_INDICE_LEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWAP  = 3'd1,
        S_SWEEP = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                         r_state_q,     w_state_d;
    logic [SIGNED_INDICE_LEN-1:0]   r_frag_idx_q,  w_frag_idx_d;
    logic                           r_chg_idx_q,   w_chg_idx_d;
    logic                           r_sig_valid_q, w_sig_valid_d;
    logic                           r_busy_q,      w_busy_d;
    logic                           r_drain_q,     w_drain_d;
    logic [FRAG_LEN-1:0]            r_s1_data_q,   w_s1_data_d;
    logic                           r_s1_vld_q,    w_s1_vld_d;
    logic [c_SIG_W-1:0]             r_s2_hash_q,   w_s2_hash_d;
    logic                           r_s2_vld_q,    w_s2_vld_d;
    logic [c_SIG_W-1:0]             r_min_q,       w_min_d;
    logic [HASH_BITS-1:0]           w_s1_ext;

    // Control: the index register doubles as the sweep counter.
    always_comb begin
        w_state_d     = r_state_q;
        w_frag_idx_d  = '0;
        w_chg_idx_d   = 1'b0;
        w_sig_valid_d = 1'b0;
        w_drain_d     = r_drain_q;
        case (r_state_q)
            S_IDLE: begin
                if (en && fm_wait) begin
                    w_state_d   = S_SWAP;
                    w_chg_idx_d = 1'b1;
                end
            end
            S_SWAP: begin
                w_state_d    = S_SWEEP;
                w_frag_idx_d = c_START_IDX;
            end
            S_SWEEP: begin
                if (r_frag_idx_q == c_END_IDX) begin
                    w_state_d = S_DRAIN;
                    w_drain_d = 1'b0;
                end else begin
                    w_frag_idx_d = r_frag_idx_q + c_IDX_ONE;
                end
            end
            S_DRAIN: begin
                if (r_drain_q) begin
                    w_state_d     = S_OUT;
                    w_sig_valid_d = 1'b1;
                end else begin
                    w_drain_d = 1'b1;
                end
            end
            S_OUT: begin
                if (sig_ready) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_sig_valid_d = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    // Datapath: s1 captures the fragment, s2 the hashes, then the min fold.
    always_comb begin
        w_s1_data_d = frag_data;
        w_s1_vld_d  = (r_state_q == S_SWEEP);
        w_s2_vld_d  = r_s1_vld_q;
    end

    assign w_s1_ext = HASH_BITS'(r_s1_data_q);

    genvar k;
    generate
        for (k = 0; k < HASH_COUNT; k++) begin : g_hash
            logic [HASH_BITS-1:0] w_a;
            logic [HASH_BITS-1:0] w_b;
            logic [HASH_BITS-1:0] w_h;
            logic [HASH_BITS-1:0] w_m;
            assign w_a = HASH_A[k*HASH_BITS +: HASH_BITS];
            assign w_b = HASH_B[k*HASH_BITS +: HASH_BITS];
            assign w_h = r_s2_hash_q[k*HASH_BITS +: HASH_BITS];
            assign w_m = r_min_q[k*HASH_BITS +: HASH_BITS];
            assign w_s2_hash_d[k*HASH_BITS +: HASH_BITS] = w_a * w_s1_ext + w_b;
            // Strict compare: equal hashes keep the stored minimum.
            assign w_min_d[k*HASH_BITS +: HASH_BITS] =
                (r_state_q == S_SWAP)           ? {HASH_BITS{1'b1}} :
                (r_s2_vld_q && (w_h < w_m))     ? w_h : w_m;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_frag_idx_q  <= '0;
            r_chg_idx_q   <= 1'b0;
            r_sig_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_drain_q     <= 1'b0;
            r_s1_data_q   <= '0;
            r_s1_vld_q    <= 1'b0;
            r_s2_hash_q   <= '0;
            r_s2_vld_q    <= 1'b0;
            r_min_q       <= '1;
        end else begin
            r_state_q     <= w_state_d;
            r_frag_idx_q  <= w_frag_idx_d;
            r_chg_idx_q   <= w_chg_idx_d;
            r_sig_valid_q <= w_sig_valid_d;
            r_busy_q      <= w_busy_d;
            r_drain_q     <= w_drain_d;
            r_s1_data_q   <= w_s1_data_d;
            r_s1_vld_q    <= w_s1_vld_d;
            r_s2_hash_q   <= w_s2_hash_d;
            r_s2_vld_q    <= w_s2_vld_d;
            r_min_q       <= w_min_d;
        end
    end

    assign frag_idx  = r_frag_idx_q;
    assign chg_idx   = r_chg_idx_q;
    assign sig_valid = r_sig_valid_q;
    assign sig_data  = r_min_q;
    assign busy      = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_proj_minhash_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proj_minhash_sweep
//  Description : Scoreboard bench with a two-bank feature-map model and a
//                MinHash reference computed straight from the hash definition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proj_minhash_sweep;

    localparam int c_N          = 29;
    localparam int c_FRAG_START = -4;
    localparam longint c_HA [4] = '{64'h9E37, 64'h85EB, 64'hC2B2, 64'h27D4};
    localparam longint c_HB [4] = '{64'h0001, 64'h0003, 64'h0005, 64'h0007};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fm_wait;
    logic [15:0] frag_data;
    logic [5:0]  frag_idx;
    logic        chg_idx;
    logic        sig_valid;
    logic        sig_ready;
    logic [63:0] sig_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    logic [15:0] pend [c_N];
    logic [15:0] cur  [c_N];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    proj_minhash_sweep dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fm_wait   (fm_wait),
        .frag_data (frag_data),
        .frag_idx  (frag_idx),
        .chg_idx   (chg_idx),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .sig_data  (sig_data),
        .busy      (busy)
    );

    // Feature map: the pending bank becomes readable after a swap pulse.
    always @(posedge clk) begin
        if (chg_idx) begin
            for (int i = 0; i < c_N; i++) cur[i] <= pend[i];
        end
    end

    always_comb begin
        int off;
        off = int'($signed(frag_idx)) - c_FRAG_START;
        frag_data = 16'hDEAD;
        if (off >= 0 && off < c_N) frag_data = cur[off];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] ref_sig();
        logic [63:0] s;
        longint best;
        longint h;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            best = 64'hFFFF;
            for (int i = 0; i < c_N; i++) begin
                h = (c_HA[k] * longint'(pend[i]) + c_HB[k]) % 65536;
                if (h < best) best = h;
            end
            s[k*16 +: 16] = best[15:0];
        end
        return s;
    endfunction

    // Monitor: every cycle the signature is presented it must match the head.
    always @(negedge clk) begin
        if (!rst && sig_valid) begin
            if (exp_q.size() == 0) begin
                check("sig_unexpected", 64'd1, 64'd0);
            end else begin
                check("sig_data", sig_data, exp_q[0]);
                if (sig_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_frag_idx"}, 64'(frag_idx), 64'd0);
        check({tag, "_chg_idx"}, 64'(chg_idx), 64'd0);
        check({tag, "_sig_valid"}, 64'(sig_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sig_data"}, sig_data, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic run_sweep(input int hold, input int abort_at, input bit b2b);
        logic [5:0] e_idx;
        if (!armed) begin
            @(posedge clk); #1; en = 1'b1; fm_wait = 1'b1; sig_ready = 1'b0;
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_chg", 64'(chg_idx), 64'd0);
        end
        armed = 1'b0;
        @(posedge clk); #1; en = 1'($urandom); fm_wait = 1'($urandom);
        exp_q.push_back(ref_sig());
        @(negedge clk);
        check("swap_chg", 64'(chg_idx), 64'd1);
        check("swap_busy", 64'(busy), 64'd1);
        for (int i = 0; i < c_N; i++) begin
            @(posedge clk); #1; en = 1'($urandom); fm_wait = 1'($urandom);
            if (i + 2 == abort_at) begin
                rst = 1'b1; en = 1'b0; fm_wait = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                exp_q.delete();
                @(negedge clk); rst = 1'b0;
                return;
            end
            @(negedge clk);
            e_idx = 6'(c_FRAG_START + i);
            check("sweep_idx", 64'(frag_idx), 64'(e_idx));
            check("sweep_chg", 64'(chg_idx), 64'd0);
            check("sweep_valid", 64'(sig_valid), 64'd0);
        end
        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("drain_valid", 64'(sig_valid), 64'd0);
            check("drain_idx", 64'(frag_idx), 64'd0);
            check("drain_busy", 64'(busy), 64'd1);
        end
        for (int j = 0; j <= hold; j++) begin
            @(posedge clk); #1;
            sig_ready = (j == hold); en = 1'($urandom); fm_wait = 1'($urandom);
            @(negedge clk);
            check("out_valid", 64'(sig_valid), 64'd1);
            check("out_busy", 64'(busy), 64'd1);
            check("out_chg", 64'(chg_idx), 64'd0);
        end
        @(posedge clk); #1; sig_ready = 1'b0; en = 1'b1; fm_wait = b2b;
        @(negedge clk);
        check("ret_idle_valid", 64'(sig_valid), 64'd0);
        check("ret_idle_busy", 64'(busy), 64'd0);
        armed = b2b;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fm_wait = 1'b0; sig_ready = 1'b0;
        for (int i = 0; i < c_N; i++) begin pend[i] = 16'h0; cur[i] = 16'h0; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk); rst = 1'b0;

        // All-zero fragments: signature equals the addends.
        run_sweep(0, 0, 1'b0);
        // Descending ramp, long backpressure, back-to-back next sweep.
        for (int i = 0; i < c_N; i++) pend[i] = 16'(1000 - 7 * i);
        run_sweep(10, 0, 1'b1);
        // Constant data: every later hash ties the first one.
        for (int i = 0; i < c_N; i++) pend[i] = 16'h1234;
        run_sweep(3, 0, 1'b0);
        // Reset mid-sweep, then a fresh sweep over the same bank.
        for (int i = 0; i < c_N; i++) pend[i] = 16'($urandom);
        run_sweep(0, 10, 1'b0);
        run_sweep(2, 0, 1'b0);
        // Enable low: writer waiting must not start a sweep.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1; en = 1'b0; fm_wait = 1'b1;
            @(negedge clk);
            check("en_low_chg", 64'(chg_idx), 64'd0);
            check("en_low_busy", 64'(busy), 64'd0);
        end
        for (int i = 0; i < c_N; i++) pend[i] = 16'hFFFF;
        run_sweep(1, 0, 1'b0);
        // Randomized sweeps: full-range data and narrow-range data (many ties).
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < c_N; i++)
                pend[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
            run_sweep(int'($urandom_range(0, 10)), 0, 1'($urandom_range(0, 1)));
        end
        if (armed) begin
            @(posedge clk); #1; en = 1'b0; fm_wait = 1'b0;
            @(negedge clk);
            check("final_swap_chg", 64'(chg_idx), 64'd1);
        end
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/proj_minhash_sweep.md
# proj_minhash_sweep

Downstream consumer of the feature-map double buffer. When the buffer's writer has filled a bank and stalls, this block swaps banks (`chg_idx`) and sweeps the signed fragment index over a programmed range, reading one padded fragment per cycle. It hashes each fragment with `HASH_COUNT` affine hash functions, keeps the running minimum per function, and presents the resulting MinHash signature on a valid/ready output.

## Interface
- `FRAG_LEN`, 16, fragment width in bits.
- `SIGNED_INDICE_LEN`, 6, width of the signed fragment index.
- `FRAG_START`, -4, first fragment index of a sweep (signed, two's complement).
- `FRAG_END`, 24, last fragment index of a sweep (signed); requires `FRAG_END >= FRAG_START`.
- `HASH_COUNT`, 4, number of hash functions.
- `HASH_BITS`, 16, hash and signature element width; requires `HASH_BITS >= FRAG_LEN`.
- `HASH_A`, {16'h27D4,16'hC2B2,16'h85EB,16'h9E37}, packed multipliers; function k uses `[k*HASH_BITS +: HASH_BITS]`.
- `HASH_B`, {16'h0007,16'h0005,16'h0003,16'h0001}, packed addends, same packing.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  allows leaving IDLE.
- `fm_wait`  in  1  feature-map writer holding with a full bank.
- `frag_data`  in  FRAG_LEN  padded fragment returned combinationally for the current `frag_idx`.
- `frag_idx`  out  SIGNED_INDICE_LEN  fragment index to the feature map (registered).
- `chg_idx`  out  1  bank-swap pulse to the feature map (registered).
- `sig_valid`  out  1  signature available.
- `sig_ready`  in  1  consumer accepts the signature.
- `sig_data`  out  HASH_COUNT*HASH_BITS  signature; element k at `[k*HASH_BITS +: HASH_BITS]`.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, SWAP, SWEEP, DRAIN, OUT.
- IDLE: if `en & fm_wait`, go to SWAP.
- SWAP: exactly one cycle. `chg_idx`=1. All min registers are loaded with all-ones. Go to SWEEP.
- SWEEP: `frag_idx` = FRAG_START, FRAG_START+1, …, FRAG_END, one value per cycle. N = FRAG_END-FRAG_START+1 cycles. After FRAG_END, go to DRAIN.
- Pipeline:
  - s1 registers `frag_data` together with a valid bit.
  - s2 registers h_k = (A_k * zero_ext(s1) + B_k) mod 2^HASH_BITS. The product and sum are truncated to HASH_BITS bits.
  - min stage: if s2 is valid and h_k < min_k (strict), min_k <= h_k. Ties keep the old value.
- DRAIN: exactly 2 cycles (pipeline flush). Then go to OUT.
- OUT: `sig_valid`=1 and `sig_data`=min registers, held stable until `sig_ready`=1. The handshake cycle moves the state to IDLE.
- Outside SWEEP: `frag_idx`=0.
- Outside SWAP: `chg_idx`=0.
- `sig_ready` is ignored when `sig_valid`=0.
- `fm_wait` is ignored outside IDLE.
- `en` is sampled only in IDLE. Deasserting it mid-sweep has no effect.
- Reset (at any time, including mid-sweep):
  - state=IDLE, `frag_idx`=0, `chg_idx`=0, `sig_valid`=0, `busy`=0.
  - s1/s2 valid bits=0; min registers and `sig_data` all-ones.

## Timing
- Cycle 0: IDLE samples `en & fm_wait`=1.
- Cycle 1: SWAP, `chg_idx`=1. The feature map swaps banks at the end of cycle 1.
- Cycles 2..N+1: SWEEP, with `frag_idx` = FRAG_START+(c-2).
- Cycles N+2..N+3: DRAIN.
- Cycle N+4: OUT. First cycle with `sig_valid`=1 and the final signature.
- Minimum sweep-to-sweep spacing: the handshake in cycle t returns to IDLE at t+1; the next SWAP is at t+2 at the earliest.
- Default sweep: N=29, first `sig_valid` at cycle 33.
- `busy` = 1 from cycle 1 through the handshake cycle.
- `chg_idx` is never asserted for more than one consecutive cycle.

## Test plan
- Reset then `en`=1, `fm_wait`=1, `frag_data`=0 throughout:
  - `chg_idx` pulses once at cycle 1.
  - `frag_idx` runs -4..24 over cycles 2..30.
  - At cycle 33, `sig_valid`=1 and `sig_data` = {7,5,3,1}.
- Override `HASH_A`=all 16'h0001, `HASH_B`=0. Drive `frag_data` = 1000 - 7*(cycle index within sweep), which reaches 804 at the last index. Every element of `sig_data` = 804.
- Tie and wrap: `HASH_A`=1, `HASH_B`=16'hFFFF, `frag_data`=16'h0001 every cycle. Every element = 16'h0000 (mod wrap). A repeated equal value leaves the min unchanged.
- Backpressure: hold `sig_ready`=0 for 10 cycles in OUT.
  - `sig_valid`, `sig_data` and `busy` stay stable.
  - `fm_wait` toggling causes no `chg_idx`.
  - `sig_ready`=1 leads to IDLE next cycle; with `fm_wait`=1, a new SWAP follows one cycle later.
- Assert `rst` asynchronously at cycle 10 of a sweep:
  - Outputs are immediately at reset values.
  - After release with `fm_wait`=1, a complete fresh sweep yields the same signature as an uninterrupted run.
- `en`=0 with `fm_wait`=1 for 20 cycles: no `chg_idx`, `busy`=0. Raising `en` starts SWAP on the next cycle.
